// File: rtl/selector_cursor_ctrl_pkg.sv
// Shared constants for the keypad selection cursor: grid defaults, key FSM
// encoding and the border-comparator zone codes of the selection strip.
package selector_cursor_ctrl_pkg;

  localparam int N_COL_DEF  = 9;
  localparam int N_ROW_DEF  = 3;

  localparam int SEL_X_BASE = 10;
  localparam int SEL_Y_ROW0 = 8;
  localparam int DEFAULT_X  = 31;
  localparam int DEFAULT_Y  = 15;

  typedef enum logic [1:0] {
    KEY_IDLE    = 2'd0,
    KEY_PEND    = 2'd1,
    KEY_RELEASE = 2'd2
  } key_state_e;

  function automatic logic [4:0] key_index(input logic [1:0] row,
                                           input logic [3:0] col,
                                           input int         n_col);
    return 5'(int'(row) * n_col + int'(col));
  endfunction

endpackage

// File: rtl/selector_cursor_ctrl_edge_rise.sv
// Rising-edge detector for one clk-synchronous button level.
module edge_rise (
  input  logic clk,
  input  logic lvl_i,
  output logic rise_o
);

  logic lvl_q;

  // The copy tracks the level even in reset, so a button held through reset
  // produces no event afterwards.
  always_ff @(posedge clk) begin
    lvl_q <= lvl_i;
  end

  assign rise_o = lvl_i & ~lvl_q;

endmodule

// File: rtl/selector_cursor_ctrl.sv
// Keypad selection cursor: button-driven cursor with wrap, key handshake FSM,
// blinking highlight and the per-pixel selection-strip hit.
//
// state       | meaning
// KEY_IDLE    | waiting for a btn_ok rising edge
// KEY_PEND    | key_valid high, key_code held until key_ready
// KEY_RELEASE | transfer done, waiting for btn_ok to go low
module selector_cursor_ctrl
  import selector_cursor_ctrl_pkg::*;
#(
  parameter int N_COL        = N_COL_DEF,
  parameter int N_ROW        = N_ROW_DEF,
  parameter int BLINK_FRAMES = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_ok,
  input  logic       key_ready,
  input  logic [4:0] zone_x,
  input  logic [3:0] zone_y,
  output logic [3:0] sel_col,
  output logic [1:0] sel_row,
  output logic       highlight_on,
  output logic       sel_hit,
  output logic       key_valid,
  output logic [4:0] key_code
);

  localparam int             CW           = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0]  BLINK_RELOAD = CW'(BLINK_FRAMES - 1);

  logic rise_up, rise_down, rise_left, rise_right, rise_ok;

  edge_rise u_up    (.clk(clk), .lvl_i(btn_up),    .rise_o(rise_up));
  edge_rise u_down  (.clk(clk), .lvl_i(btn_down),  .rise_o(rise_down));
  edge_rise u_left  (.clk(clk), .lvl_i(btn_left),  .rise_o(rise_left));
  edge_rise u_right (.clk(clk), .lvl_i(btn_right), .rise_o(rise_right));
  edge_rise u_ok    (.clk(clk), .lvl_i(btn_ok),    .rise_o(rise_ok));

  logic [3:0]    col_q, col_d;
  logic [1:0]    row_q, row_d;
  logic          hl_q, hl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          kv_q, kv_d;
  logic [4:0]    kc_q, kc_d;
  key_state_e    state_q, state_d;
  logic          any_move;

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    any_move = rise_up | rise_down | rise_left | rise_right;
    if (rise_up) begin
      row_d = (row_q == 2'd0) ? 2'(N_ROW - 1) : row_q - 2'd1;
    end else if (rise_down) begin
      row_d = (row_q == 2'(N_ROW - 1)) ? 2'd0 : row_q + 2'd1;
    end else if (rise_left) begin
      col_d = (col_q == 4'd0) ? 4'(N_COL - 1) : col_q - 4'd1;
    end else if (rise_right) begin
      col_d = (col_q == 4'(N_COL - 1)) ? 4'd0 : col_q + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    kv_d    = kv_q;
    kc_d    = kc_q;
    case (state_q)
      KEY_IDLE: begin
        if (rise_ok) begin
          kc_d    = key_index(row_q, col_q, N_COL);
          kv_d    = 1'b1;
          state_d = KEY_PEND;
        end
      end
      KEY_PEND: begin
        if (key_ready) begin
          kv_d    = 1'b0;
          state_d = KEY_RELEASE;
        end
      end
      KEY_RELEASE: begin
        if (!btn_ok) state_d = KEY_IDLE;
      end
      default: state_d = KEY_IDLE;
    endcase
  end

  // Holding the mark on through the exit cycle makes blinking restart at phase 1, count 0.
  always_comb begin
    hl_d  = hl_q;
    cnt_d = cnt_q;
    if (any_move || state_q == KEY_PEND || state_d == KEY_PEND) begin
      hl_d  = 1'b1;
      cnt_d = BLINK_RELOAD;
    end else if (frame_tick) begin
      if (cnt_q == '0) begin
        hl_d  = ~hl_q;
        cnt_d = BLINK_RELOAD;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q   <= 4'd0;
      row_q   <= 2'd0;
      hl_q    <= 1'b1;
      cnt_q   <= BLINK_RELOAD;
      kv_q    <= 1'b0;
      kc_q    <= 5'd0;
      state_q <= KEY_IDLE;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      hl_q    <= hl_d;
      cnt_q   <= cnt_d;
      kv_q    <= kv_d;
      kc_q    <= kc_d;
      state_q <= state_d;
    end
  end

  assign sel_col      = col_q;
  assign sel_row      = row_q;
  assign highlight_on = hl_q;
  assign key_valid    = kv_q;
  assign key_code     = kc_q;

  assign sel_hit = hl_q
                && (zone_x != 5'(DEFAULT_X)) && (zone_y != 4'(DEFAULT_Y))
                && (zone_x == 5'(SEL_X_BASE + int'(col_q)))
                && (zone_y == 4'(SEL_Y_ROW0 - int'(row_q)));

endmodule

// File: tb/tb_selector_cursor_ctrl.sv
// Directed bench for selector_cursor_ctrl with BLINK_FRAMES=2.
module tb_selector_cursor_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, frame_tick;
  logic       btn_up, btn_down, btn_left, btn_right, btn_ok, key_ready;
  logic [4:0] zone_x;
  logic [3:0] zone_y;
  logic [3:0] sel_col;
  logic [1:0] sel_row;
  logic       highlight_on, sel_hit, key_valid;
  logic [4:0] key_code;

  int tests_run    = 0;
  int tests_failed = 0;

  selector_cursor_ctrl #(.N_COL(9), .N_ROW(3), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_ok(btn_ok), .key_ready(key_ready),
    .zone_x(zone_x), .zone_y(zone_y),
    .sel_col(sel_col), .sel_row(sel_row), .highlight_on(highlight_on),
    .sel_hit(sel_hit), .key_valid(key_valid), .key_code(key_code)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // b: 0=up 1=down 2=left 3=right
  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_up    = v;
      1: btn_down  = v;
      2: btn_left  = v;
      default: btn_right = v;
    endcase
  endtask

  task automatic pulse(input int b);
    set_btn(b, 1'b1);
    step();
    set_btn(b, 1'b0);
    step();
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    tests_run++;
    if ({sel_col, sel_row, highlight_on, key_valid, key_code} !== {4'd0, 2'd0, 1'b1, 1'b0, 5'd0}) begin
      tests_failed++;
      $display("FAIL reset_state: got col=%0d row=%0d hl=%0b kv=%0b code=%0d, want 0 0 1 0 0",
               sel_col, sel_row, highlight_on, key_valid, key_code);
    end
    tests_run++;
    if (sel_hit !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_hit_default_zone: got %0b want 0", sel_hit);
    end
    zone_x = 5'd10; zone_y = 4'd8;
    #1;
    tests_run++;
    if (sel_hit !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_hit_origin: got %0b want 1", sel_hit);
    end
    zone_x = 5'd31; zone_y = 4'd15;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_right_wrap();
    logic [3:0] exp_col [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd0, 4'd1};
    for (int i = 0; i < 10; i++) begin
      pulse(3);
      tests_run++;
      if ({sel_col, sel_row} !== {exp_col[i], 2'd0}) begin
        tests_failed++;
        $display("FAIL right_wrap[%0d]: got col=%0d row=%0d want col=%0d row=0",
                 i, sel_col, sel_row, exp_col[i]);
      end
    end
  endtask

  task automatic test_up_down();
    pulse(0);
    tests_run++;
    if ({sel_col, sel_row} !== {4'd1, 2'd2}) begin
      tests_failed++;
      $display("FAIL up_wrap: got col=%0d row=%0d want 1 2", sel_col, sel_row);
    end
    pulse(1);
    tests_run++;
    if ({sel_col, sel_row} !== {4'd1, 2'd0}) begin
      tests_failed++;
      $display("FAIL down_wrap: got col=%0d row=%0d want 1 0", sel_col, sel_row);
    end
    btn_up = 1'b1; btn_left = 1'b1;
    step();
    tests_run++;
    if ({sel_col, sel_row} !== {4'd1, 2'd2}) begin
      tests_failed++;
      $display("FAIL up_left_priority: got col=%0d row=%0d want 1 2", sel_col, sel_row);
    end
    step(); step(); step();
    tests_run++;
    if ({sel_col, sel_row} !== {4'd1, 2'd2}) begin
      tests_failed++;
      $display("FAIL held_single_event: got col=%0d row=%0d want 1 2", sel_col, sel_row);
    end
    btn_up = 1'b0; btn_left = 1'b0;
    step();
  endtask

  task automatic test_key();
    pulse(1); pulse(1);
    pulse(3); pulse(3); pulse(3);
    tests_run++;
    if ({sel_col, sel_row} !== {4'd4, 2'd1}) begin
      tests_failed++;
      $display("FAIL key_setup_pos: got col=%0d row=%0d want 4 1", sel_col, sel_row);
    end
    key_ready = 1'b0;
    btn_ok = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if ({key_valid, key_code, highlight_on} !== {1'b1, 5'd13, 1'b1}) begin
        tests_failed++;
        $display("FAIL key_pend_hold[%0d]: got kv=%0b code=%0d hl=%0b want 1 13 1",
                 i, key_valid, key_code, highlight_on);
      end
      step();
    end
    pulse(3);
    tests_run++;
    if ({sel_col, key_valid, key_code} !== {4'd5, 1'b1, 5'd13}) begin
      tests_failed++;
      $display("FAIL key_move_in_pend: got col=%0d kv=%0b code=%0d want 5 1 13",
               sel_col, key_valid, key_code);
    end
    key_ready = 1'b1;
    step();
    key_ready = 1'b0;
    tests_run++;
    if (key_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL key_handshake_drop: got kv=%0b want 0", key_valid);
    end
    step(); step(); step();
    tests_run++;
    if (key_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL key_held_ignored: got kv=%0b want 0", key_valid);
    end
    btn_ok = 1'b0;
    step();
    btn_ok = 1'b1;
    step();
    tests_run++;
    if ({key_valid, key_code} !== {1'b1, 5'd14}) begin
      tests_failed++;
      $display("FAIL key_second_press: got kv=%0b code=%0d want 1 14", key_valid, key_code);
    end
    key_ready = 1'b1;
    step();
    key_ready = 1'b0; btn_ok = 1'b0;
    step();
    btn_ok = 1'b1; btn_right = 1'b1;
    step();
    tests_run++;
    if ({key_valid, key_code, sel_col} !== {1'b1, 5'd14, 4'd6}) begin
      tests_failed++;
      $display("FAIL key_premove_latch: got kv=%0b code=%0d col=%0d want 1 14 6",
               key_valid, key_code, sel_col);
    end
    key_ready = 1'b1;
    step();
    key_ready = 1'b0; btn_ok = 1'b0; btn_right = 1'b0;
    step();
  endtask

  task automatic test_blink();
    logic exp6 [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic exp3 [3] = '{1'b1, 1'b0, 1'b0};
    pulse(2);
    for (int i = 0; i < 6; i++) begin
      tick();
      tests_run++;
      if (highlight_on !== exp6[i]) begin
        tests_failed++;
        $display("FAIL blink_tick[%0d]: got hl=%0b want %0b", i + 1, highlight_on, exp6[i]);
      end
    end
    pulse(2);
    for (int i = 0; i < 3; i++) tick();
    tests_run++;
    if (highlight_on !== exp3[2]) begin
      tests_failed++;
      $display("FAIL blink_pre_move: got hl=%0b want %0b", highlight_on, exp3[2]);
    end
    pulse(2);
    tests_run++;
    if (highlight_on !== 1'b1) begin
      tests_failed++;
      $display("FAIL blink_move_force: got hl=%0b want 1", highlight_on);
    end
    tick();
    tests_run++;
    if (highlight_on !== 1'b1) begin
      tests_failed++;
      $display("FAIL blink_tick4: got hl=%0b want 1", highlight_on);
    end
    tick();
    tests_run++;
    if (highlight_on !== 1'b0) begin
      tests_failed++;
      $display("FAIL blink_tick5: got hl=%0b want 0", highlight_on);
    end
    btn_ok = 1'b1;
    step();
    for (int i = 0; i < 4; i++) tick();
    tests_run++;
    if ({key_valid, highlight_on} !== {1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL blink_pend_steady: got kv=%0b hl=%0b want 1 1", key_valid, highlight_on);
    end
    key_ready = 1'b1;
    step();
    key_ready = 1'b0;
    tick();
    tests_run++;
    if (highlight_on !== 1'b1) begin
      tests_failed++;
      $display("FAIL blink_resume_t1: got hl=%0b want 1", highlight_on);
    end
    tick();
    tests_run++;
    if (highlight_on !== 1'b0) begin
      tests_failed++;
      $display("FAIL blink_resume_t2: got hl=%0b want 0", highlight_on);
    end
    btn_ok = 1'b0;
    step();
  endtask

  task automatic test_sel_hit();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    pulse(0);
    pulse(2);
    zone_x = 5'd18; zone_y = 4'd6;
    #1;
    tests_run++;
    if ({sel_col, sel_row, sel_hit} !== {4'd8, 2'd2, 1'b1}) begin
      tests_failed++;
      $display("FAIL hit_match: got col=%0d row=%0d hit=%0b want 8 2 1", sel_col, sel_row, sel_hit);
    end
    zone_y = 4'd8;
    #1;
    tests_run++;
    if (sel_hit !== 1'b0) begin
      tests_failed++;
      $display("FAIL hit_wrong_row: got %0b want 0", sel_hit);
    end
    zone_x = 5'd17; zone_y = 4'd6;
    #1;
    tests_run++;
    if (sel_hit !== 1'b0) begin
      tests_failed++;
      $display("FAIL hit_wrong_col: got %0b want 0", sel_hit);
    end
    zone_x = 5'd18;
    tick();
    tick();
    tests_run++;
    if ({highlight_on, sel_hit} !== {1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL hit_blink_off: got hl=%0b hit=%0b want 0 0", highlight_on, sel_hit);
    end
    zone_x = 5'd31; zone_y = 4'd15;
    step();
  endtask

  task automatic test_reset_in_pend();
    btn_ok = 1'b1;
    step();
    tests_run++;
    if ({key_valid, key_code} !== {1'b1, 5'd26}) begin
      tests_failed++;
      $display("FAIL rstpend_enter: got kv=%0b code=%0d want 1 26", key_valid, key_code);
    end
    btn_right = 1'b1;
    rst_n = 1'b0;
    step();
    tests_run++;
    if ({sel_col, sel_row, highlight_on, key_valid, key_code} !== {4'd0, 2'd0, 1'b1, 1'b0, 5'd0}) begin
      tests_failed++;
      $display("FAIL rstpend_values: got col=%0d row=%0d hl=%0b kv=%0b code=%0d want 0 0 1 0 0",
               sel_col, sel_row, highlight_on, key_valid, key_code);
    end
    rst_n = 1'b1;
    step(); step(); step();
    tests_run++;
    if ({sel_col, key_valid} !== {4'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL rstpend_held_no_event: got col=%0d kv=%0b want 0 0", sel_col, key_valid);
    end
    btn_right = 1'b0; btn_ok = 1'b0;
    step();
    pulse(3);
    tests_run++;
    if (sel_col !== 4'd1) begin
      tests_failed++;
      $display("FAIL rstpend_repress: got col=%0d want 1", sel_col);
    end
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; key_ready = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_ok = 1'b0;
    zone_x = 5'd31; zone_y = 4'd15;
    test_reset();
    test_right_wrap();
    test_up_down();
    test_key();
    test_blink();
    test_sel_hit();
    test_reset_in_pend();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
